// File: rtl/regfile_dump_reader.sv
// Register-file dump reader.
// Walks a (possibly wrapping) index range through a spare combinational read
// port and streams {index, data} beats to a valid/ready sink. The output stage
// is a single registered beat: a new beat is captured whenever the stage is
// empty or its current beat is being accepted, which gives one beat per cycle
// under continuous ready and holds the beat stable under backpressure.
module regfile_dump_reader #(
  parameter int XLEN  = 64,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [IDX_W-1:0] first_idx,
  input  logic [IDX_W-1:0] last_idx,
  output logic [IDX_W-1:0] rf_rs,
  input  logic [XLEN-1:0]  rf_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [XLEN-1:0]  out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  // One bit wider than the index so a full 2**IDX_W beat dump fits.
  logic [IDX_W:0]   remaining;

  logic [IDX_W-1:0] span;
  logic [IDX_W:0]   beat_count;
  logic             load;
  logic             final_beat;

  // Modular distance makes first > last wrap through index 0.
  assign span       = last_idx - first_idx;
  assign beat_count = {1'b0, span} + (IDX_W+1)'(1);

  // The output register may take a new beat when empty or being drained.
  assign load       = !out_valid || out_ready;
  assign final_beat = (remaining == (IDX_W+1)'(1));

  // Read port is only driven while walking; parked at 0 otherwise.
  assign rf_rs = (state == RUN) ? ptr : '0;
  assign busy  = (state != IDLE);

  // Control FSM and registered output beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      // done is a single-cycle pulse; only the final handshake raises it.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            ptr       <= first_idx;
            remaining <= beat_count;
            state     <= RUN;
          end
        end

        RUN: begin
          if (abort) begin
            // Any pending beat is discarded, even one accepted this cycle.
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            state     <= IDLE;
          end else if (load) begin
            // Snapshot of the read data at this edge; a same-edge write is not seen.
            out_data  <= rf_rdata;
            out_idx   <= ptr;
            out_last  <= final_beat;
            out_valid <= 1'b1;
            ptr       <= ptr + IDX_W'(1);
            remaining <= remaining - (IDX_W+1)'(1);
            if (final_beat) begin
              state <= DRAIN;
            end
          end
        end

        DRAIN: begin
          if (abort) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            state     <= IDLE;
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed testbench for regfile_dump_reader.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [4:0]  first_idx;
  logic [4:0]  last_idx;
  logic [4:0]  rf_rs;
  logic [63:0] rf_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_idx;
  logic [63:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;

  logic        wr_en;
  logic [4:0]  wr_idx;
  logic [63:0] wr_data;
  logic [63:0] regs [32];

  int errors = 0;
  int checks = 0;

  regfile_dump_reader #(.XLEN(64), .IDX_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .first_idx (first_idx),
    .last_idx  (last_idx),
    .rf_rs     (rf_rs),
    .rf_rdata  (rf_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Register file: preset contents while in reset, one write port otherwise.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 64'd0;
      regs[5]  <= 64'd15;
      regs[22] <= 64'd1;
      regs[24] <= 64'd15;
    end else if (wr_en) begin
      regs[wr_idx] <= wr_data;
    end
  end

  assign rf_rdata = (rf_rs == 5'd0) ? 64'd0 : regs[rf_rs];

  // Preset register contents, written out by hand.
  function automatic logic [63:0] init_val(input int idx);
    case (idx)
      5:       return 64'd15;
      22:      return 64'd1;
      24:      return 64'd15;
      default: return 64'd0;
    endcase
  endfunction

  // Pulse start for one edge; returns at the falling edge after the start edge.
  task automatic kick(input logic [4:0] f, input logic [4:0] l);
    first_idx = f;
    last_idx  = l;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    checks++; if (out_idx !== 5'd0) begin errors++; $display("FAIL reset_idx got=%0d want=0", out_idx); end
    checks++; if (out_data !== 64'd0) begin errors++; $display("FAIL reset_data got=%h want=0", out_data); end
    checks++; if (out_last !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_flags got last=%b done=%b busy=%b want 0,0,0", out_last, done, busy); end
    checks++; if (rf_rs !== 5'd0) begin errors++; $display("FAIL reset_rs got=%0d want=0", rf_rs); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_idle got busy=%b done=%b want 0,0", busy, done); end
    $display("reset released");
  endtask

  task automatic test_full_dump;
    out_ready = 1'b1;
    kick(5'd0, 5'd31);
    checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL t1_pre got busy=%b valid=%b want 1,0", busy, out_valid); end
    for (int j = 0; j < 32; j++) begin
      @(negedge clk);
      $display("t1 beat idx=%0d data=%0h last=%b", out_idx, out_data, out_last);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL t1_valid beat %0d got=%b want=1", j, out_valid); end
      checks++; if (out_idx !== 5'(j)) begin errors++; $display("FAIL t1_idx beat %0d got=%0d want=%0d", j, out_idx, j); end
      checks++; if (out_data !== init_val(j)) begin errors++; $display("FAIL t1_data beat %0d got=%0h want=%0h", j, out_data, init_val(j)); end
      checks++; if (out_last !== (j == 31)) begin errors++; $display("FAIL t1_last beat %0d got=%b want=%b", j, out_last, (j == 31)); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL t1_early_done beat %0d got=%b want=0", j, done); end
      checks++; if (rf_rs !== ((j == 31) ? 5'd0 : 5'(j + 1))) begin errors++; $display("FAIL t1_rs beat %0d got=%0d want=%0d", j, rf_rs, (j == 31) ? 0 : j + 1); end
    end
    @(negedge clk);
    checks++; if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL t1_done got done=%b busy=%b valid=%b want 1,0,0", done, busy, out_valid); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL t1_done_width got=%b want=0", done); end
  endtask

  task automatic test_backpressure;
    logic       pattern [4];
    logic [4:0] exp_idx;
    logic [4:0] held_idx;
    logic [63:0] held_data;
    logic       held_last;
    logic       held_valid;
    int         hs;
    int         dones;
    pattern[0] = 1'b1; pattern[1] = 1'b0; pattern[2] = 1'b0; pattern[3] = 1'b1;
    exp_idx = 5'd4; hs = 0; dones = 0; held_valid = 1'b0;
    held_idx = '0; held_data = '0; held_last = 1'b0;
    out_ready = 1'b1;
    kick(5'd4, 5'd7);
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1) dones++;
      if (held_valid) begin
        checks++;
        if (out_valid !== 1'b1 || out_idx !== held_idx || out_data !== held_data || out_last !== held_last) begin
          errors++;
          $display("FAIL t2_stable cycle %0d got v=%b idx=%0d data=%0h last=%b want v=1 idx=%0d data=%0h last=%b",
                   c, out_valid, out_idx, out_data, out_last, held_idx, held_data, held_last);
        end
      end
      // A start while a dump is running must be ignored.
      if (c == 3) begin
        start = 1'b1; first_idx = 5'd0; last_idx = 5'd31;
      end else begin
        start = 1'b0;
      end
      out_ready = pattern[c % 4];
      if (out_valid === 1'b1 && out_ready) begin
        $display("t2 beat idx=%0d data=%0h last=%b", out_idx, out_data, out_last);
        checks++; if (out_idx !== exp_idx) begin errors++; $display("FAIL t2_idx hs %0d got=%0d want=%0d", hs, out_idx, exp_idx); end
        checks++; if (out_data !== init_val(int'(exp_idx))) begin errors++; $display("FAIL t2_data hs %0d got=%0h want=%0h", hs, out_data, init_val(int'(exp_idx))); end
        checks++; if (out_last !== (exp_idx == 5'd7)) begin errors++; $display("FAIL t2_last hs %0d got=%b want=%b", hs, out_last, (exp_idx == 5'd7)); end
        exp_idx = exp_idx + 5'd1;
        hs++;
      end
      held_valid = (out_valid === 1'b1) && !out_ready;
      held_idx   = out_idx;
      held_data  = out_data;
      held_last  = out_last;
      @(negedge clk);
    end
    start = 1'b0;
    checks++; if (hs != 4) begin errors++; $display("FAIL t2_count got=%0d want=4", hs); end
    checks++; if (dones != 1) begin errors++; $display("FAIL t2_dones got=%0d want=1", dones); end
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL t2_end got busy=%b valid=%b want 0,0", busy, out_valid); end
  endtask

  task automatic test_wrap;
    logic [4:0] exp_idx;
    out_ready = 1'b1;
    kick(5'd30, 5'd1);
    checks++; if (rf_rs !== 5'd30) begin errors++; $display("FAIL t3_rs got=%0d want=30", rf_rs); end
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      exp_idx = 5'(30 + j);
      $display("t3 beat idx=%0d data=%0h last=%b", out_idx, out_data, out_last);
      checks++; if (out_valid !== 1'b1 || out_idx !== exp_idx) begin errors++; $display("FAIL t3_idx beat %0d got v=%b idx=%0d want v=1 idx=%0d", j, out_valid, out_idx, exp_idx); end
      checks++; if (out_data !== 64'd0) begin errors++; $display("FAIL t3_data beat %0d got=%0h want=0", j, out_data); end
      checks++; if (out_last !== (j == 3)) begin errors++; $display("FAIL t3_last beat %0d got=%b want=%b", j, out_last, (j == 3)); end
    end
    @(negedge clk);
    checks++; if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL t3_done got done=%b busy=%b valid=%b want 1,0,0", done, busy, out_valid); end
  endtask

  task automatic test_single;
    // start together with abort is ignored
    first_idx = 5'd22; last_idx = 5'd22; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL t4_start_abort got busy=%b valid=%b want 0,0", busy, out_valid); end
    out_ready = 1'b1;
    kick(5'd22, 5'd22);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t4_busy got=%b want=1", busy); end
    @(negedge clk);
    $display("t4 beat idx=%0d data=%0h last=%b", out_idx, out_data, out_last);
    checks++; if (out_valid !== 1'b1 || out_idx !== 5'd22) begin errors++; $display("FAIL t4_idx got v=%b idx=%0d want v=1 idx=22", out_valid, out_idx); end
    checks++; if (out_data !== 64'd1 || out_last !== 1'b1) begin errors++; $display("FAIL t4_data got data=%0h last=%b want data=1 last=1", out_data, out_last); end
    @(negedge clk);
    checks++; if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL t4_done got done=%b busy=%b valid=%b want 1,0,0", done, busy, out_valid); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL t4_done_width got=%b want=0", done); end
  endtask

  task automatic test_collision;
    logic [63:0] want;
    out_ready = 1'b1;
    kick(5'd0, 5'd31);
    for (int j = 0; j < 32; j++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_idx !== 5'(j)) begin errors++; $display("FAIL t5a_idx beat %0d got v=%b idx=%0d want v=1 idx=%0d", j, out_valid, out_idx, j); end
      if (j == 23) begin
        $display("t5a beat idx=%0d data=%0h", out_idx, out_data);
        checks++; if (out_data !== 64'd0) begin errors++; $display("FAIL t5a_old_value got=%0h want=0", out_data); end
      end
      // Write x23 on the same edge that loads beat 23.
      wr_en   = (j == 22);
      wr_idx  = 5'd23;
      wr_data = 64'hDEAD;
    end
    wr_en = 1'b0;
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL t5a_done got=%b want=1", done); end
    kick(5'd0, 5'd31);
    for (int j = 0; j < 32; j++) begin
      @(negedge clk);
      want = (j == 23) ? 64'hDEAD : init_val(j);
      if (j == 23) $display("t5b beat idx=%0d data=%0h", out_idx, out_data);
      checks++; if (out_valid !== 1'b1 || out_idx !== 5'(j) || out_data !== want) begin errors++; $display("FAIL t5b_beat %0d got v=%b idx=%0d data=%0h want v=1 idx=%0d data=%0h", j, out_valid, out_idx, out_data, j, want); end
    end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL t5b_done got=%b want=1", done); end
  endtask

  task automatic test_abort_reset;
    out_ready = 1'b1;
    kick(5'd0, 5'd31);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_idx !== 5'(j)) begin errors++; $display("FAIL t6_pre_idx beat %0d got v=%b idx=%0d want v=1 idx=%0d", j, out_valid, out_idx, j); end
    end
    @(negedge clk);
    checks++; if (out_idx !== 5'd3) begin errors++; $display("FAIL t6_beat3 got=%0d want=3", out_idx); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    $display("t6 abort issued");
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_last !== 1'b0) begin errors++; $display("FAIL t6_abort got v=%b busy=%b done=%b last=%b want 0,0,0,0", out_valid, busy, done, out_last); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (done !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL t6_after_abort cycle %0d got done=%b v=%b want 0,0", c, done, out_valid); end
    end
    kick(5'd5, 5'd5);
    @(negedge clk);
    $display("t6 restart beat idx=%0d data=%0h", out_idx, out_data);
    checks++; if (out_valid !== 1'b1 || out_idx !== 5'd5 || out_data !== 64'd15) begin errors++; $display("FAIL t6_restart got v=%b idx=%0d data=%0h want v=1 idx=5 data=f", out_valid, out_idx, out_data); end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL t6_restart_done got=%b want=1", done); end
    kick(5'd0, 5'd31);
    for (int j = 0; j < 6; j++) @(negedge clk);
    checks++; if (out_idx !== 5'd5 || out_data !== 64'd15) begin errors++; $display("FAIL t6_pre_rst got idx=%0d data=%0h want idx=5 data=f", out_idx, out_data); end
    #1 rst = 1'b1;
    #1;
    $display("t6 reset asserted mid-dump");
    checks++; if (out_valid !== 1'b0 || out_idx !== 5'd0 || out_data !== 64'd0) begin errors++; $display("FAIL t6_rst_out got v=%b idx=%0d data=%0h want 0,0,0", out_valid, out_idx, out_data); end
    checks++; if (busy !== 1'b0 || rf_rs !== 5'd0 || out_last !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL t6_rst_flags got busy=%b rs=%0d last=%b done=%b want 0,0,0,0", busy, rf_rs, out_last, done); end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL t6_post_rst cycle %0d got done=%b busy=%b want 0,0", c, done, busy); end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    first_idx = '0; last_idx = '0;
    wr_en = 1'b0; wr_idx = '0; wr_data = '0;
    test_reset;
    test_full_dump;
    test_backpressure;
    test_wrap;
    test_single;
    test_collision;
    test_abort_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
